// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_pkg
// Brief   : Opcodes, decoder state encoding and operand register addresses.
// Revision: 1.0
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned c_opnd_a_addr = 0;
    localparam int unsigned c_opnd_b_addr = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_ALU_A   = 3'd4,
        ST_ALU_B   = 3'd5,
        ST_ALU_FUN = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_decoder_if
// Brief   : Receive-byte input and register-file / ALU command outputs.
// Revision: 1.0
// ============================================================================
interface uart_cmd_decoder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
);
    logic [DATA_W-1:0] rx_p_data;
    logic              rx_d_vld;
    logic              rx_err;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              alu_en;
    logic [FUN_W-1:0]  alu_fun;
    logic              alu_clk_en;
    logic              cmd_err;
    logic              busy;

    modport master (
        output rx_p_data, rx_d_vld, rx_err,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
        input  alu_en, alu_fun, alu_clk_en, cmd_err, busy
    );

    modport slave (
        input  rx_p_data, rx_d_vld, rx_err,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
        output alu_en, alu_fun, alu_clk_en, cmd_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder_frame_timer.sv
`default_nettype none
// ============================================================================
// Module  : frame_timer
// Brief   : Saturating inter-byte idle counter with an expiry flag.
// Revision: 1.0
// ============================================================================
module frame_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != CNT_W'(TIMEOUT_CYC))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the cycle whose increment makes the count reach TIMEOUT_CYC,
    // so the abort lands on the same edge.
    assign expired = en && (r_count >= CNT_W'(TIMEOUT_CYC - 1));
endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_decoder
// Brief   : Assembles UART bytes into register-file write/read and ALU strobes.
// Revision: 1.0
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_cmd_decoder_if.slave  bus
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_rf_addr, w_rf_addr;
    logic [DATA_W-1:0] r_rf_wr_data, w_rf_wr_data;
    logic [FUN_W-1:0]  r_alu_fun, w_alu_fun;
    logic              r_rf_wr_en, r_rf_rd_en, r_alu_en, r_cmd_err;
    logic              r_alu_clk_en, r_busy;
    logic              w_wr_en, w_rd_en, w_alu_en, w_cmd_err;
    logic              w_in_frame, w_abort_err, w_abort_to, w_accept;
    logic              w_addr_bad, w_expired;

    assign w_in_frame  = (r_state != ST_IDLE);
    assign w_abort_err = w_in_frame && bus.rx_err;
    assign w_accept    = bus.rx_d_vld && !w_abort_err;
    assign w_abort_to  = w_expired && !bus.rx_d_vld;
    assign w_addr_bad  = |bus.rx_p_data[DATA_W-1:ADDR_W];

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .en      (w_in_frame),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_rf_addr    = r_rf_addr;
        w_rf_wr_data = r_rf_wr_data;
        w_alu_fun    = r_alu_fun;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_alu_en     = 1'b0;
        w_cmd_err    = 1'b0;
        if (w_abort_err || w_abort_to) begin
            w_state_nxt = ST_IDLE;
            w_cmd_err   = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    case (bus.rx_p_data)
                        DATA_W'(CMD_RF_WR):   w_state_nxt = ST_WR_ADDR;
                        DATA_W'(CMD_RF_RD):   w_state_nxt = ST_RD_ADDR;
                        DATA_W'(CMD_ALU_OP):  w_state_nxt = ST_ALU_A;
                        DATA_W'(CMD_ALU_NOP): w_state_nxt = ST_ALU_FUN;
                        default:              w_cmd_err   = 1'b1;
                    endcase
                end
                ST_WR_ADDR: begin
                    if (w_addr_bad) begin
                        w_cmd_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_addr_nxt  = bus.rx_p_data[ADDR_W-1:0];
                        w_state_nxt = ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    w_wr_en      = 1'b1;
                    w_rf_addr    = r_addr;
                    w_rf_wr_data = bus.rx_p_data;
                    w_state_nxt  = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    if (w_addr_bad) begin
                        w_cmd_err = 1'b1;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_rf_addr = bus.rx_p_data[ADDR_W-1:0];
                    end
                    w_state_nxt = ST_IDLE;
                end
                ST_ALU_A: begin
                    w_wr_en      = 1'b1;
                    w_rf_addr    = ADDR_W'(c_opnd_a_addr);
                    w_rf_wr_data = bus.rx_p_data;
                    w_state_nxt  = ST_ALU_B;
                end
                ST_ALU_B: begin
                    w_wr_en      = 1'b1;
                    w_rf_addr    = ADDR_W'(c_opnd_b_addr);
                    w_rf_wr_data = bus.rx_p_data;
                    w_state_nxt  = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    w_alu_en    = 1'b1;
                    w_alu_fun   = bus.rx_p_data[FUN_W-1:0];
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rf_addr    <= '0;
            r_rf_wr_data <= '0;
            r_alu_fun    <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_rd_en   <= 1'b0;
            r_alu_en     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_alu_clk_en <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_rf_addr    <= w_rf_addr;
            r_rf_wr_data <= w_rf_wr_data;
            r_alu_fun    <= w_alu_fun;
            r_rf_wr_en   <= w_wr_en;
            r_rf_rd_en   <= w_rd_en;
            r_alu_en     <= w_alu_en;
            r_cmd_err    <= w_cmd_err;
            // Registered from next state so the gate opens with ALU_FUN itself.
            r_alu_clk_en <= (w_state_nxt == ST_ALU_FUN) || w_alu_en;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.rf_wr_en   = r_rf_wr_en;
    assign bus.rf_rd_en   = r_rf_rd_en;
    assign bus.rf_addr    = r_rf_addr;
    assign bus.rf_wr_data = r_rf_wr_data;
    assign bus.alu_en     = r_alu_en;
    assign bus.alu_fun    = r_alu_fun;
    assign bus.alu_clk_en = r_alu_clk_en;
    assign bus.cmd_err    = r_cmd_err;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire
